multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control FSM for the non-pipelined MIPS-style processor. It decodes the latched instruction and sequences the fetch, decode, ALU, memory and write-back stages one state per cycle. It also drives the select, function and load-enable lines for the PC, IR, register file, ALU stage (ALU_Bin_sel, ALU_func) and data memory. It consumes the ALU Zero flag for branches and a memory acknowledge for variable-latency loads and stores.

## Interface
Parameters:
- MEM_TIMEOUT, 16, maximum cycles spent waiting for Mem_ack before abandoning the access

Ports (name, direction, width, meaning):
- Clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high; sampled on Clk rising edge
- Instr  in  32  IR contents (opcode Instr[31:26], R-type func Instr[5:0])
- Zero  in  1  ALU zero flag
- Mem_ack  in  1  data memory completed current access
- PC_sel  out  1  0 = PC+4, 1 = branch target
- PC_LdEn  out  1  PC register load enable
- IR_LdEn  out  1  instruction register load enable
- RF_WrEn  out  1  register file write enable
- RF_WrData_sel  out  1  0 = ALU result, 1 = memory data
- RF_B_sel  out  1  0 = Instr[15:11], 1 = Instr[20:16] as second read address
- ALU_Bin_sel  out  1  0 = RF_B, 1 = Immed
- ALU_func  out  4  ALU operation code
- ImmExt  out  2  00 sign-extend, 01 zero-extend, 10 sign-extend <<2, 11 upper <<16
- Mem_WrEn  out  1  data memory write strobe
- Mem_RdEn  out  1  data memory read strobe
- Mem_err  out  1  sticky; set on Mem_ack timeout, cleared only by Reset

## Operation
- States: IFETCH, DECODE, EXEC, MEM, WB.
- Outputs are a combinational function of state and Instr. Every enable is 0 outside the states listed below.
- IFETCH: IR_LdEn=1, PC_LdEn=1, PC_sel=0. Next state DECODE.
- DECODE: RF_B_sel set per class. Next state EXEC for legal opcodes. Illegal opcodes go to IFETCH and execute as a NOP.
- EXEC: ALU_Bin_sel, ALU_func and ImmExt driven per class.
  - R-type (opcode 100000): ALU_func = Instr[3:0], ALU_Bin_sel=0. Next state WB.
  - addi 110000 (add, sext), andi 110010 (and, zext), ori 110011 (or, zext), li 111000 (add, sext), lui 111001 (add, upper): ALU_Bin_sel=1. Next state WB.
  - lw 001111 / sw 011111: add, sext. Next state MEM.
  - beq 000000 / bne 000001: sub, ALU_Bin_sel=0. PC_LdEn=PC_sel=(Zero for beq, !Zero for bne), ImmExt=10. Next state IFETCH.
  - b 111111: PC_LdEn=PC_sel=1, ImmExt=10. Next state IFETCH.
- MEM: ALU controls held from EXEC.
  - Mem_RdEn=1 (lw) or Mem_WrEn=1 (sw) held until Mem_ack.
  - On Mem_ack: lw goes to WB, sw goes to IFETCH.
  - A 4-bit wait counter increments each cycle without ack. When it reaches MEM_TIMEOUT-1 with no ack: Mem_err=1, strobes drop, next state IFETCH.
- WB: RF_WrEn=1 for exactly one cycle. RF_WrData_sel=1 for lw, else 0. ALU controls held from EXEC. Next state IFETCH.
- ALU_func encoding (shared): 0000 add, 0001 sub, 0010 and, 0011 or, 0100 not, 0101 nand, 0110 nor, 1000 sra, 1001 srl, 1010 sll, 1100 rol, 1101 ror.

## Timing
- Reset: state=IFETCH, wait counter=0, Mem_err=0.
  - All enables and strobes read 0 while Reset is high.
  - ALU_func=0000, ALU_Bin_sel=0, ImmExt=00.
  - Reset mid-instruction aborts with no further writes. The first fetch occurs in the cycle after Reset deasserts.
- Cycles per instruction:
  - branch/b: 3
  - R-type/immediate: 4
  - sw: 4+w
  - lw: 5+w
  - w = wait cycles before Mem_ack (w=0 when ack is in the first MEM cycle)
- Mem_ack is sampled only in MEM and ignored elsewhere. Ack on the same edge as the timeout counts as success.
- Zero is sampled combinationally in EXEC only.
- Exactly one PC_LdEn pulse per IFETCH. A taken branch produces one additional pulse in EXEC.

## Structure
- Shared package (control_pkg) holds:
  - opcode localparams
  - ALU_func codes
  - ImmExt codes
  - state enumeration (3-bit)
- Sub-module: mc_decoder, purely combinational. Maps Instr to an instruction class plus EXEC-stage ALU_func, ALU_Bin_sel and ImmExt.
- Top-level FSM registers only: state, wait counter, Mem_err, and a latched lw/sw flag.

## Test plan
- Reset held 2 cycles, then released with Instr=R-type add (100000, func 000000), Mem_ack=0:
  - states follow IFETCH, DECODE, EXEC, WB, IFETCH
  - ALU_func=0000 and ALU_Bin_sel=0 in EXEC
  - RF_WrEn high exactly 1 cycle
- beq with Zero=1 → PC_LdEn=PC_sel=1 in EXEC, ImmExt=10. beq with Zero=0 → PC_LdEn=0 in EXEC. Both return to IFETCH after 3 cycles.
- lw with Mem_ack asserted on the 3rd MEM cycle → Mem_RdEn high 3 cycles, then WB with RF_WrData_sel=1. Total 7 cycles.
- sw with Mem_ack never asserted, MEM_TIMEOUT=16 → Mem_WrEn high 16 cycles, Mem_err=1, return to IFETCH, Mem_err stays 1 until Reset.
- Illegal opcode 010101 → IFETCH, DECODE, IFETCH with no RF_WrEn or memory strobe.
- Reset asserted during MEM of a lw → all strobes 0 that cycle, state=IFETCH next, no RF write.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the multi-cycle control path: opcodes, ALU function codes,
// immediate-extension modes, FSM states and decoded instruction classes.
package control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_B     = 6'b111111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_NOT  = 4'b0100;
    localparam logic [3:0] ALU_NAND = 4'b0101;
    localparam logic [3:0] ALU_NOR  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_ROL  = 4'b1100;
    localparam logic [3:0] ALU_ROR  = 4'b1101;

    localparam logic [1:0] IMM_SEXT     = 2'b00;
    localparam logic [1:0] IMM_ZEXT     = 2'b01;
    localparam logic [1:0] IMM_SEXT_SH2 = 2'b10;
    localparam logic [1:0] IMM_UPPER    = 2'b11;

    typedef enum logic [2:0] {
        ST_IFETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_t;

    typedef enum logic [2:0] {
        CL_ILLEGAL,
        CL_RTYPE,
        CL_IMM,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_BNE,
        CL_B
    } instr_class_t;

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction decoder: classifies the opcode and produces the
// EXEC-stage ALU function, B-operand select and immediate-extension mode.
module mc_decoder
    import control_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [3:0]   func,
    output instr_class_t instr_class,
    output logic [3:0]   alu_func,
    output logic         alu_bin_sel,
    output logic [1:0]   imm_ext
);

    always_comb begin
        instr_class = CL_ILLEGAL;
        alu_func    = ALU_ADD;
        alu_bin_sel = 1'b0;
        imm_ext     = IMM_SEXT;
        case (opcode)
            OP_RTYPE: begin
                instr_class = CL_RTYPE;
                alu_func    = func;
            end
            OP_ADDI, OP_LI: begin
                instr_class = CL_IMM;
                alu_bin_sel = 1'b1;
            end
            OP_ANDI: begin
                instr_class = CL_IMM;
                alu_func    = ALU_AND;
                alu_bin_sel = 1'b1;
                imm_ext     = IMM_ZEXT;
            end
            OP_ORI: begin
                instr_class = CL_IMM;
                alu_func    = ALU_OR;
                alu_bin_sel = 1'b1;
                imm_ext     = IMM_ZEXT;
            end
            OP_LUI: begin
                instr_class = CL_IMM;
                alu_bin_sel = 1'b1;
                imm_ext     = IMM_UPPER;
            end
            // Address generation for memory ops is base register plus immediate.
            OP_LW: begin
                instr_class = CL_LW;
                alu_bin_sel = 1'b1;
            end
            OP_SW: begin
                instr_class = CL_SW;
                alu_bin_sel = 1'b1;
            end
            OP_BEQ: begin
                instr_class = CL_BEQ;
                alu_func    = ALU_SUB;
                imm_ext     = IMM_SEXT_SH2;
            end
            OP_BNE: begin
                instr_class = CL_BNE;
                alu_func    = ALU_SUB;
                imm_ext     = IMM_SEXT_SH2;
            end
            OP_B: begin
                instr_class = CL_B;
                imm_ext     = IMM_SEXT_SH2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences IFETCH/DECODE/EXEC/MEM/WB one state per cycle
// and drives the datapath enables, selects and memory strobes.
module multicycle_control
    import control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        Mem_ack,
    output logic        PC_sel,
    output logic        PC_LdEn,
    output logic        IR_LdEn,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        RF_B_sel,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic [1:0]  ImmExt,
    output logic        Mem_WrEn,
    output logic        Mem_RdEn,
    output logic        Mem_err
);

    state_t       state, next_state;
    logic [3:0]   wait_cnt;
    logic         is_load;
    instr_class_t instr_class;
    logic [3:0]   dec_alu_func;
    logic         dec_bin_sel;
    logic [1:0]   dec_imm_ext;
    logic         mem_timeout;
    logic         branch_taken;
    logic         class_b_sel;
    logic         unused_instr_bits;

    assign unused_instr_bits = ^Instr[25:4];

    mc_decoder u_decoder (
        .opcode      (Instr[31:26]),
        .func        (Instr[3:0]),
        .instr_class (instr_class),
        .alu_func    (dec_alu_func),
        .alu_bin_sel (dec_bin_sel),
        .imm_ext     (dec_imm_ext)
    );

    assign mem_timeout  = (wait_cnt == 4'(MEM_TIMEOUT - 1));
    assign branch_taken = ((instr_class == CL_BEQ) && Zero) ||
                          ((instr_class == CL_BNE) && !Zero) ||
                          (instr_class == CL_B);
    // Stores and branches need the Instr[20:16] register on the second read port.
    assign class_b_sel  = (instr_class == CL_SW) || (instr_class == CL_BEQ) ||
                          (instr_class == CL_BNE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IFETCH;
            wait_cnt <= 4'd0;
            Mem_err  <= 1'b0;
            is_load  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_EXEC)
                is_load <= (instr_class == CL_LW);
            if ((state == ST_MEM) && !Mem_ack && !mem_timeout)
                wait_cnt <= wait_cnt + 4'd1;
            else
                wait_cnt <= 4'd0;
            if ((state == ST_MEM) && !Mem_ack && mem_timeout)
                Mem_err <= 1'b1;
        end
    end

    always_comb begin
        next_state    = ST_IFETCH;
        PC_sel        = 1'b0;
        PC_LdEn       = 1'b0;
        IR_LdEn       = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = ALU_ADD;
        ImmExt        = IMM_SEXT;
        Mem_WrEn      = 1'b0;
        Mem_RdEn      = 1'b0;

        case (state)
            ST_IFETCH: next_state = ST_DECODE;
            ST_DECODE: next_state = (instr_class == CL_ILLEGAL) ? ST_IFETCH : ST_EXEC;
            ST_EXEC: begin
                case (instr_class)
                    CL_RTYPE, CL_IMM: next_state = ST_WB;
                    CL_LW, CL_SW:     next_state = ST_MEM;
                    default:          next_state = ST_IFETCH;
                endcase
            end
            // An ack arriving on the timeout cycle still completes the access.
            ST_MEM: begin
                if (Mem_ack)
                    next_state = is_load ? ST_WB : ST_IFETCH;
                else if (mem_timeout)
                    next_state = ST_IFETCH;
                else
                    next_state = ST_MEM;
            end
            default: next_state = ST_IFETCH;
        endcase

        if (!Reset) begin
            case (state)
                ST_IFETCH: begin
                    IR_LdEn = 1'b1;
                    PC_LdEn = 1'b1;
                end
                ST_DECODE: RF_B_sel = class_b_sel;
                ST_EXEC: begin
                    RF_B_sel    = class_b_sel;
                    ALU_func    = dec_alu_func;
                    ALU_Bin_sel = dec_bin_sel;
                    ImmExt      = dec_imm_ext;
                    PC_LdEn     = branch_taken;
                    PC_sel      = branch_taken;
                end
                ST_MEM: begin
                    RF_B_sel    = class_b_sel;
                    ALU_func    = dec_alu_func;
                    ALU_Bin_sel = dec_bin_sel;
                    ImmExt      = dec_imm_ext;
                    Mem_RdEn    = is_load;
                    Mem_WrEn    = !is_load;
                end
                ST_WB: begin
                    RF_B_sel      = class_b_sel;
                    ALU_func      = dec_alu_func;
                    ALU_Bin_sel   = dec_bin_sel;
                    ImmExt        = dec_imm_ext;
                    RF_WrEn       = 1'b1;
                    RF_WrData_sel = is_load;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level model expands each
// instruction into its expected per-cycle output trace, checked every cycle.
module tb_multicycle_control;

    localparam int MEM_TIMEOUT = 16;

    typedef struct {
        bit       rst, ack, zero;
        bit       ir, pc_ld, pc_sel, rf_wr, wd_sel, mem_rd, mem_wr;
        bit       alu_chk;
        bit [3:0] alu_func;
        bit       bin_chk, bin_sel;
        bit       imm_chk;
        bit [1:0] imm;
        bit       rfb_chk, rfb;
        bit       err_chk, err;
    } cyc_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Instr = 32'h0;
    logic        Zero = 1'b0;
    logic        Mem_ack = 1'b0;
    logic        PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel;
    logic        ALU_Bin_sel, Mem_WrEn, Mem_RdEn, Mem_err;
    logic [3:0]  ALU_func;
    logic [1:0]  ImmExt;

    cyc_t trace[$];
    cyc_t cur;
    bit   cur_valid = 1'b0;
    bit   model_err = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;
    int   rf_wr_seen = 0;
    int   pc_ld_seen = 0;

    multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Instr         (Instr),
        .Zero          (Zero),
        .Mem_ack       (Mem_ack),
        .PC_sel        (PC_sel),
        .PC_LdEn       (PC_LdEn),
        .IR_LdEn       (IR_LdEn),
        .RF_WrEn       (RF_WrEn),
        .RF_WrData_sel (RF_WrData_sel),
        .RF_B_sel      (RF_B_sel),
        .ALU_Bin_sel   (ALU_Bin_sel),
        .ALU_func      (ALU_func),
        .ImmExt        (ImmExt),
        .Mem_WrEn      (Mem_WrEn),
        .Mem_RdEn      (Mem_RdEn),
        .Mem_err       (Mem_err)
    );

    always #5 Clk = ~Clk;

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkBits(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle_no, act, exp);
        end
    endtask

    // Compares every DUT output against the expected cycle record.
    task automatic checkOutput(input cyc_t c);
        checkBits("IR_LdEn", {3'b0, IR_LdEn}, {3'b0, c.ir});
        checkBits("PC_LdEn", {3'b0, PC_LdEn}, {3'b0, c.pc_ld});
        checkBits("PC_sel", {3'b0, PC_sel}, {3'b0, c.pc_sel});
        checkBits("RF_WrEn", {3'b0, RF_WrEn}, {3'b0, c.rf_wr});
        checkBits("Mem_RdEn", {3'b0, Mem_RdEn}, {3'b0, c.mem_rd});
        checkBits("Mem_WrEn", {3'b0, Mem_WrEn}, {3'b0, c.mem_wr});
        if (c.rf_wr)   checkBits("RF_WrData_sel", {3'b0, RF_WrData_sel}, {3'b0, c.wd_sel});
        if (c.alu_chk) checkBits("ALU_func", ALU_func, c.alu_func);
        if (c.bin_chk) checkBits("ALU_Bin_sel", {3'b0, ALU_Bin_sel}, {3'b0, c.bin_sel});
        if (c.imm_chk) checkBits("ImmExt", {2'b0, ImmExt}, {2'b0, c.imm});
        if (c.rfb_chk) checkBits("RF_B_sel", {3'b0, RF_B_sel}, {3'b0, c.rfb});
        if (c.err_chk) checkBits("Mem_err", {3'b0, Mem_err}, {3'b0, c.err});
    endtask

    always @(negedge Clk) begin
        if (cur_valid) begin
            checkOutput(cur);
            if (RF_WrEn) rf_wr_seen++;
            if (PC_LdEn) pc_ld_seen++;
            cycle_no++;
        end
    end

    function automatic cyc_t blankCycle(input bit zero_val);
        cyc_t c;
        c = '{default: 0};
        c.zero    = zero_val;
        c.err_chk = 1'b1;
        c.err     = model_err;
        return c;
    endfunction

    function automatic void buildReset(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = '{default: 0};
            c.rst     = 1'b1;
            c.alu_chk = 1'b1;
            c.bin_chk = 1'b1;
            c.imm_chk = 1'b1;
            c.err_chk = (i > 0);
            trace.push_back(c);
        end
        model_err = 1'b0;
    endfunction

    // Expands one instruction into its cycle trace; ack_at is the MEM cycle index of
    // Mem_ack (-1 = never), mem_limit truncates the MEM phase (for reset-abort tests).
    function automatic void buildInstr(input logic [31:0] instr, input bit zero,
                                       input int ack_at, input int mem_limit);
        cyc_t       c;
        logic [5:0] op;
        bit         legal, is_br, is_mem, is_ld, wb, taken, achk, bchk, bsel, ichk, rchk, rsel;
        bit [3:0]   f;
        bit [1:0]   im;
        op = instr[31:26];
        legal = 1; is_br = 0; is_mem = 0; is_ld = 0; wb = 0; taken = 0;
        achk = 1; bchk = 1; bsel = 1; ichk = 1; rchk = 0; rsel = 0;
        f = 4'b0000; im = 2'b00;
        case (op)
            6'b100000: begin f = instr[3:0]; bsel = 0; ichk = 0; rchk = 1; wb = 1; end
            6'b110000: wb = 1;
            6'b110010: begin f = 4'b0010; im = 2'b01; wb = 1; end
            6'b110011: begin f = 4'b0011; im = 2'b01; wb = 1; end
            6'b111000: wb = 1;
            6'b111001: begin im = 2'b11; wb = 1; end
            6'b001111: begin is_mem = 1; is_ld = 1; bchk = 0; end
            6'b011111: begin is_mem = 1; bchk = 0; rchk = 1; rsel = 1; end
            6'b000000: begin is_br = 1; f = 4'b0001; bsel = 0; im = 2'b10; taken = zero;
                             rchk = 1; rsel = 1; end
            6'b000001: begin is_br = 1; f = 4'b0001; bsel = 0; im = 2'b10; taken = !zero;
                             rchk = 1; rsel = 1; end
            6'b111111: begin is_br = 1; achk = 0; bchk = 0; im = 2'b10; taken = 1; end
            default:   legal = 0;
        endcase

        c = blankCycle(!zero);
        c.ir = 1; c.pc_ld = 1;
        trace.push_back(c);
        c = blankCycle(!zero);
        c.rfb_chk = rchk; c.rfb = rsel;
        trace.push_back(c);
        if (!legal) return;

        c = blankCycle(zero);
        c.alu_chk = achk; c.alu_func = f; c.bin_chk = bchk; c.bin_sel = bsel;
        c.imm_chk = ichk; c.imm = im;
        c.pc_ld = taken; c.pc_sel = taken;
        trace.push_back(c);
        if (is_br) return;

        if (is_mem) begin
            for (int k = 0; k < MEM_TIMEOUT; k++) begin
                if (k >= mem_limit) return;
                c = blankCycle(!zero);
                c.alu_chk = achk; c.alu_func = f; c.imm_chk = ichk; c.imm = im;
                c.mem_rd = is_ld; c.mem_wr = !is_ld;
                c.ack = (k == ack_at);
                trace.push_back(c);
                if (c.ack) break;
                if (k == MEM_TIMEOUT - 1) begin
                    model_err = 1'b1;
                    return;
                end
            end
            if (!is_ld) return;
        end

        if (wb || is_ld) begin
            c = blankCycle(!zero);
            c.alu_chk = achk; c.alu_func = f; c.bin_chk = bchk; c.bin_sel = bsel;
            c.imm_chk = ichk; c.imm = im;
            c.rf_wr = 1; c.wd_sel = is_ld;
            trace.push_back(c);
        end
    endfunction

    function automatic int countField(input int which);
        int n = 0;
        foreach (trace[i]) begin
            if (which == 0 && trace[i].mem_rd) n++;
            if (which == 1 && trace[i].mem_wr) n++;
        end
        return n;
    endfunction

    // Drives the queued trace one cycle at a time, just after each rising edge.
    task automatic applyStimulus(input logic [31:0] instr);
        cyc_t c;
        while (trace.size() > 0) begin
            c = trace.pop_front();
            @(posedge Clk);
            #1;
            Instr     = instr;
            Reset     = c.rst;
            Mem_ack   = c.ack;
            Zero      = c.zero;
            cur       = c;
            cur_valid = 1'b1;
        end
        @(negedge Clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD  = {6'b100000, 20'h12345, 6'b000000};
    localparam logic [31:0] I_ROL  = {6'b100000, 20'h0abcd, 6'b001100};
    localparam logic [31:0] I_BEQ  = {6'b000000, 26'h0000010};
    localparam logic [31:0] I_BNE  = {6'b000001, 26'h0000020};
    localparam logic [31:0] I_B    = {6'b111111, 26'h3ffffff};
    localparam logic [31:0] I_LW   = {6'b001111, 26'h0000004};
    localparam logic [31:0] I_SW   = {6'b011111, 26'h0000008};
    localparam logic [31:0] I_ILL  = {6'b010101, 26'h1555555};

    initial begin
        int rf0, pc0;
        logic [5:0] imm_ops [5];
        imm_ops = '{6'b110000, 6'b110010, 6'b110011, 6'b111000, 6'b111001};
        $display("[TB] starting multicycle_control bench");

        buildReset(2);
        applyStimulus(32'h0);

        buildInstr(I_ADD, 0, -1, 99);
        checkVal("rtype_len", trace.size(), 4);
        rf0 = rf_wr_seen;
        applyStimulus(I_ADD);
        checkVal("rtype_rf_pulses", rf_wr_seen - rf0, 1);

        buildInstr(I_ROL, 1, -1, 99);
        applyStimulus(I_ROL);

        for (int i = 0; i < 5; i++) begin
            buildInstr({imm_ops[i], 26'h0001234}, 0, -1, 99);
            applyStimulus({imm_ops[i], 26'h0001234});
        end

        buildInstr(I_BEQ, 1, -1, 99);
        checkVal("beq_len", trace.size(), 3);
        pc0 = pc_ld_seen;
        applyStimulus(I_BEQ);
        checkVal("beq_taken_pc_pulses", pc_ld_seen - pc0, 2);

        buildInstr(I_BEQ, 0, -1, 99);
        pc0 = pc_ld_seen;
        applyStimulus(I_BEQ);
        checkVal("beq_not_taken_pc_pulses", pc_ld_seen - pc0, 1);

        buildInstr(I_BNE, 0, -1, 99);
        applyStimulus(I_BNE);
        buildInstr(I_B, 0, -1, 99);
        applyStimulus(I_B);

        buildInstr(I_LW, 0, 2, 99);
        checkVal("lw_len", trace.size(), 7);
        checkVal("lw_rd_cycles", countField(0), 3);
        rf0 = rf_wr_seen;
        applyStimulus(I_LW);
        checkVal("lw_rf_pulses", rf_wr_seen - rf0, 1);

        buildInstr(I_LW, 0, 0, 99);
        applyStimulus(I_LW);
        buildInstr(I_SW, 0, 1, 99);
        checkVal("sw_len", trace.size(), 5);
        applyStimulus(I_SW);

        buildInstr(I_ILL, 0, -1, 99);
        checkVal("illegal_len", trace.size(), 2);
        rf0 = rf_wr_seen;
        applyStimulus(I_ILL);
        checkVal("illegal_rf_pulses", rf_wr_seen - rf0, 0);

        buildInstr(I_SW, 0, MEM_TIMEOUT - 1, 99);
        applyStimulus(I_SW);
        checkVal("ack_on_timeout_no_err", int'(Mem_err), 0);

        buildInstr(I_LW, 0, -1, 1);
        buildReset(1);
        rf0 = rf_wr_seen;
        applyStimulus(I_LW);
        checkVal("reset_abort_rf_pulses", rf_wr_seen - rf0, 0);

        buildInstr(I_SW, 0, -1, 99);
        checkVal("sw_timeout_len", trace.size(), 19);
        checkVal("sw_timeout_wr_cycles", countField(1), 16);
        applyStimulus(I_SW);

        buildInstr(I_ADD, 0, -1, 99);
        applyStimulus(I_ADD);
        checkVal("err_sticky", int'(Mem_err), 1);

        buildReset(2);
        applyStimulus(I_ADD);
        checkVal("err_cleared_by_reset", int'(Mem_err), 0);

        buildInstr(I_ADD, 0, -1, 99);
        applyStimulus(I_ADD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
